alu_74382_nibble_seq: RTL
=========================

# alu_74382_nibble_seq

Multi-cycle sequencer that executes wide (4·NIBBLES-bit) operations on a single 4-bit 74382 ALU core, one nibble per clock, least-significant first. It sits directly upstream of `alu_74382`: it latches a wide request, drives the core's `S`/`A`/`B`/`Cn` inputs and ripples `Cout` back into `Cn` across cycles. It then assembles the core's `F`/`OVR`/`Cout` outputs into a wide response with a valid/ready handshake.

## Interface
Parameters:
- `NIBBLES`, default 4: number of 4-bit slices per operation; W = 4·NIBBLES; legal range 1..16.
- `SEL_W`, default `alu_74382_pkg::SELECT_W` (3): opcode width.

Ports:
- `clk`, in, 1: single clock; all state rising-edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, 1: request offered.
- `req_ready`, out, 1: sequencer accepts the request this cycle.
- `req_sel`, in, SEL_W: 74382 opcode (CLEAR, B_SUB_A, A_SUB_B, ADD, XOR, OR, AND, PRESET).
- `req_a`, in, W: wide operand A.
- `req_b`, in, W: wide operand B.
- `req_cin`, in, 1: carry into nibble 0.
- `alu_sel`, out, SEL_W: to core `S`.
- `alu_a`, out, 4: to core `A`.
- `alu_b`, out, 4: to core `B`.
- `alu_cin`, out, 1: to core `Cn`.
- `alu_f`, in, 4: from core `F`; combinational, same cycle.
- `alu_ovr`, in, 1: from core `OVR`.
- `alu_cout`, in, 1: from core `Cn+4`.
- `rsp_valid`, out, 1: response held.
- `rsp_ready`, in, 1: consumer takes the response.
- `rsp_result`, out, W: assembled `F`.
- `rsp_ovr`, out, 1: `OVR` of the last nibble.
- `rsp_cout`, out, 1: `Cout` of the last nibble.
- `busy`, out, 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch sel/a/b, set `carry_q`←`req_cin` and `idx`←0, then go to RUN.
- RUN:
  - Drive `alu_sel`=sel_q, `alu_a`=a_q[4·idx+:4], `alu_b`=b_q[4·idx+:4], `alu_cin`=carry_q.
  - Each edge: res_q[4·idx+:4]←`alu_f`, carry_q←`alu_cout`, idx←idx+1.
  - When idx=NIBBLES-1: capture ovr_q←`alu_ovr` and cout_q←`alu_cout`, then go to DONE.
  - `req_ready`=0.
- DONE:
  - `rsp_valid`=1.
  - `rsp_*` hold stable until `rsp_valid`&&`rsp_ready`, then go to IDLE.
  - `req_ready`=0 (see Configuration).
- Carry ripples for every opcode, including logic ops. Flags are whatever the core reports on the final nibble. Example: CLEAR reports `OVR`=1 and `Cout`=1; the sequencer passes these through.
- Subtraction semantics belong to the core: A−B = A + ~B + Cn. A true two's-complement difference therefore requires `req_cin`=1.
- `alu_*` are 0 in IDLE and DONE.
- `idx` width is clog2(NIBBLES), with a minimum of 1 bit. For NIBBLES=1, RUN lasts exactly one cycle.
- Reset mid-operation: all state clears immediately; no response is emitted and the latched request is discarded.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_result`=0, `rsp_ovr`=0, `rsp_cout`=0, `busy`=0, `alu_*`=0.
- Request accepted at edge T. RUN occupies cycles T..T+NIBBLES-1 (post-edge). `rsp_valid` rises after edge T+NIBBLES.
- Latency, accept to `rsp_valid`: NIBBLES cycles.
- Core path is combinational within one cycle: `alu_*` → core → `alu_f`/`alu_ovr`/`alu_cout` → register.
- Minimum initiation interval: NIBBLES+2 cycles (accept, RUN×NIBBLES, response handshake, IDLE).
- `rsp_ready` may be held low indefinitely; outputs must not change while `rsp_valid`=1.
- `req_*` are sampled only at the accept edge. Later changes are ignored.

## Configuration
- `ALU_SEQ_BACK2BACK_EN`
  - Defined:
    - In DONE, `req_ready`=`rsp_ready`.
    - If both handshakes fire on the same edge, latch the new request and go straight to RUN.
    - Initiation interval becomes NIBBLES+1.
  - Undefined: DONE always returns to IDLE; `req_ready`=0 in DONE.

## Test plan
Bench instantiates the real `alu_74382` core on the `alu_*` ports, NIBBLES=4.
- ADD, a=0x00FF, b=0x0001, cin=0 → `rsp_result`=0x0100, cout=0, ovr=0; `rsp_valid` exactly 4 cycles after accept.
- A_SUB_B, a=0x1234, b=0x0234, cin=1 → 0x1000, cout=1; ADD 0x7FFF+0x0001, cin=0 → 0x8000, ovr=1, cout=0.
- XOR 0xF0F0,0xFF00 → 0x0FF0; CLEAR any operands → 0x0000, ovr=1, cout=1; PRESET → 0xFFFF.
- Hold `rsp_ready`=0 for 10 cycles with `req_valid`=1 and changed operands → response stable, `req_ready`=0, no second accept. With `ALU_SEQ_BACK2BACK_EN`, the second accept coincides with the response handshake.
- Drop `rsp_n` low during RUN idx=2 → next cycle `busy`=0, `rsp_valid`=0, `req_ready`=1, `alu_*`=0. The next request completes correctly.
- Random opcodes and operands, 1000 ops, random `req_valid`/`rsp_ready` gaps → results match the reference-model wide ALU built from the 74382 nibble truth table.

Source files
------------

// File: rtl/alu_74382_nibble_seq.sv
// alu_74382_nibble_seq
// Runs a wide (4*NIBBLES-bit) ALU operation through a single 4-bit 74382
// core, one nibble per clock, least-significant nibble first. The core's
// carry out is fed back as the next nibble's carry in, and the core outputs
// are assembled into a wide response behind a valid/ready handshake.
//
// Optional feature macro: ALU_SEQ_BACK2BACK_EN
//   defined   : a new request may be accepted on the same edge that the
//               pending response is taken (initiation interval NIBBLES+1).
//   undefined : DONE always passes through IDLE before the next request.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request, req_ready=1, core inputs held at 0
// RUN   | one nibble per cycle through the core, carry rippled in r_carry
// DONE  | response held on rsp_* until rsp_ready, core inputs held at 0

module alu_74382_nibble_seq #(
    parameter int NIBBLES = 4,
    parameter int SEL_W   = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [SEL_W-1:0]       req_sel,
    input  logic [4*NIBBLES-1:0]   req_a,
    input  logic [4*NIBBLES-1:0]   req_b,
    input  logic                   req_cin,

    output logic [SEL_W-1:0]       alu_sel,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic                   alu_cin,
    input  logic [3:0]             alu_f,
    input  logic                   alu_ovr,
    input  logic                   alu_cout,

    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [4*NIBBLES-1:0]   rsp_result,
    output logic                   rsp_ovr,
    output logic                   rsp_cout,

    output logic                   busy
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [SEL_W-1:0]    r_sel;
    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic [W-1:0]        r_res;
    logic                r_carry;
    logic [IDX_W-1:0]    r_idx;
    logic                r_ovr;
    logic                r_cout;

    logic                w_accept;
    logic                w_last;
    logic [3:0]          w_a_nib;
    logic [3:0]          w_b_nib;

    assign w_accept = req_valid && req_ready;
    assign w_last   = (r_idx == IDX_W'(NIBBLES - 1));

    // Select the operand nibbles addressed by the current index.
    always_comb begin
        w_a_nib = 4'h0;
        w_b_nib = 4'h0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx == IDX_W'(n)) begin
                w_a_nib = r_a[4*n +: 4];
                w_b_nib = r_b[4*n +: 4];
            end
        end
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake/core-drive outputs.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        alu_sel     = '0;
        alu_a       = 4'h0;
        alu_b       = 4'h0;
        alu_cin     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                alu_sel = r_sel;
                alu_a   = w_a_nib;
                alu_b   = w_b_nib;
                alu_cin = r_carry;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
`ifdef ALU_SEQ_BACK2BACK_EN
                // Taking the response frees the datapath on the same edge,
                // so a waiting request can be latched immediately.
                req_ready = rsp_ready;
                if (rsp_ready) begin
                    w_state_nxt = req_valid ? ST_RUN : ST_IDLE;
                end
`else
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latch and per-nibble accumulation of result, carry and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_ovr   <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_sel   <= req_sel;
            r_a     <= req_a;
            r_b     <= req_b;
            r_carry <= req_cin;
            r_idx   <= '0;
        end else if (r_state == ST_RUN) begin
            for (int n = 0; n < NIBBLES; n++) begin
                if (r_idx == IDX_W'(n)) begin
                    r_res[4*n +: 4] <= alu_f;
                end
            end
            r_carry <= alu_cout;
            r_idx   <= r_idx + 1'b1;
            if (w_last) begin
                // Flags reported for the whole word are those of the top nibble.
                r_ovr  <= alu_ovr;
                r_cout <= alu_cout;
            end
        end
    end

    assign rsp_result = r_res;
    assign rsp_ovr    = r_ovr;
    assign rsp_cout   = r_cout;
    assign busy       = (r_state != ST_IDLE);

endmodule
